// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg: shared types and constants for the ALU issue stage.
// Instruction word layout: {opcode[7:6], dst[5:4], src_a[3:2], src_b[1:0]}.
package alu_issue_pkg;

  localparam int REG_W   = 8;
  localparam int RF_AW   = 2;
  localparam int RF_N    = 1 << RF_AW;
  localparam int INSTR_W = 8;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  localparam int OPC_LSB  = 6;
  localparam int DST_LSB  = 4;
  localparam int SRCA_LSB = 2;
  localparam int SRCB_LSB = 0;

  // One in-flight tracker entry: a result is coming back for register dst.
  typedef struct packed {
    logic             v;
    logic [RF_AW-1:0] dst;
  } slot_t;

  // Extract a 2-bit field starting at bit lsb of an instruction word.
  function automatic logic [RF_AW-1:0] instr_field(logic [INSTR_W-1:0] w, int lsb);
    return w[lsb +: RF_AW];
  endfunction

endpackage

// File: rtl/alu_issue_unit_issue_fifo.sv
// issue_fifo: DEPTH-entry instruction queue with valid/ready push and an
// unconditional-when-non-empty pop. DEPTH must be a power of two >= 2 so
// the read/write pointers wrap naturally.
module issue_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_valid_i,
  output logic                   push_ready_o,
  input  logic [W-1:0]           push_data_i,
  input  logic                   pop_i,
  output logic [W-1:0]           head_o,
  output logic                   empty_o,
  output logic                   full_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  assign full_o       = (count_q == CW'(DEPTH));
  assign empty_o      = (count_q == '0);
  assign push_ready_o = ~full_o;
  assign head_o       = mem_q[rd_ptr_q];
  assign count_o      = count_q;
  assign do_push      = push_valid_i & ~full_o;
  assign do_pop       = pop_i & ~empty_o;

  // Storage write; entries are only read once the count says they are valid.
  // NOTE: the data array has no reset -- occupancy is tracked by the pointers,
  // so clearing payload flops would cost area and buy nothing.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  // Pointer and occupancy bookkeeping.
  // NOTE: all sequential state uses non-blocking assignment so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue_unit.sv
// alu_issue_unit: in-order issue stage in front of pipelined_alu. Queues
// instruction words, reads operands from a 4x8 register file, stalls on
// read-after-write hazards against in-flight results and writes ALU results
// back at fixed latency.
// Optional build macro: ALU_ISSUE_WB_BYPASS_EN -- forwards the retiring
// ALU result straight into an issuing operand, saving one edge of spacing.
module alu_issue_unit
  import alu_issue_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [INSTR_W-1:0] instr_data,
  output logic [1:0]         alu_opcode,
  output logic [REG_W-1:0]   alu_operand_a,
  output logic [REG_W-1:0]   alu_operand_b,
  output logic               alu_issue_valid,
  input  logic [REG_W-1:0]   alu_result,
  input  logic               rf_wr_en,
  input  logic [RF_AW-1:0]   rf_wr_addr,
  input  logic [REG_W-1:0]   rf_wr_data,
  input  logic [RF_AW-1:0]   rf_rd_addr,
  output logic [REG_W-1:0]   rf_rd_data,
  output logic               busy
);
  localparam int NSLOT = ALU_LAT + 1;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef ALU_ISSUE_WB_BYPASS_EN
  // The retiring slot is resolved by forwarding, so it never stalls issue.
  localparam int HZ_SLOTS = NSLOT - 1;
`else
  localparam int HZ_SLOTS = NSLOT;
`endif

  logic [REG_W-1:0]   rf_q [RF_N];
  slot_t              slot_q [NSLOT];
  slot_t              last_slot;

  logic [INSTR_W-1:0] head;
  logic               fifo_empty, fifo_full;
  logic [CW-1:0]      fifo_count;

  logic [1:0]         h_opc;
  logic [RF_AW-1:0]   h_dst, h_src_a, h_src_b;
  logic               hazard, inflight, issue;

  logic [1:0]         opcode_q,  opcode_d;
  logic [REG_W-1:0]   operand_a_q, operand_a_d;
  logic [REG_W-1:0]   operand_b_q, operand_b_d;
  logic               issue_valid_q, issue_valid_d;

  issue_fifo #(
    .DEPTH (DEPTH),
    .W     (INSTR_W)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_valid_i (instr_valid),
    .push_ready_o (instr_ready),
    .push_data_i  (instr_data),
    .pop_i        (issue),
    .head_o       (head),
    .empty_o      (fifo_empty),
    .full_o       (fifo_full),
    .count_o      (fifo_count)
  );

  assign h_opc     = head[OPC_LSB +: 2];
  assign h_dst     = instr_field(head, DST_LSB);
  assign h_src_a   = instr_field(head, SRCA_LSB);
  assign h_src_b   = instr_field(head, SRCB_LSB);
  assign last_slot = slot_q[NSLOT-1];

  // Hazard scan of the head's sources against pending destinations, plus
  // an overall "anything in flight" flag for busy.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    hazard   = 1'b0;
    inflight = 1'b0;
    for (int i = 0; i < NSLOT; i++) begin
      if (slot_q[i].v) inflight = 1'b1;
      if (i < HZ_SLOTS && slot_q[i].v &&
          (slot_q[i].dst == h_src_a || slot_q[i].dst == h_src_b)) hazard = 1'b1;
    end
  end

  assign issue = ~fifo_empty & ~hazard;

  // Next ALU inputs: the head's operands on issue, an all-zero bubble otherwise.
  always_comb begin
    opcode_d      = '0;
    operand_a_d   = '0;
    operand_b_d   = '0;
    issue_valid_d = 1'b0;
    if (issue) begin
      opcode_d      = h_opc;
      operand_a_d   = rf_q[h_src_a];
      operand_b_d   = rf_q[h_src_b];
      issue_valid_d = 1'b1;
`ifdef ALU_ISSUE_WB_BYPASS_EN
      if (last_slot.v && last_slot.dst == h_src_a) operand_a_d = alu_result;
      if (last_slot.v && last_slot.dst == h_src_b) operand_b_d = alu_result;
`endif
    end
  end

  // ALU-facing issue registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opcode_q      <= '0;
      operand_a_q   <= '0;
      operand_b_q   <= '0;
      issue_valid_q <= 1'b0;
    end else begin
      opcode_q      <= opcode_d;
      operand_a_q   <= operand_a_d;
      operand_b_q   <= operand_b_d;
      issue_valid_q <= issue_valid_d;
    end
  end

  // In-flight tracker: slot0 takes the issuing dst, older entries shift on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NSLOT; i++) slot_q[i] <= '0;
    end else begin
      slot_q[0] <= issue ? slot_t'{v: 1'b1, dst: h_dst} : '0;
      for (int i = 1; i < NSLOT; i++) slot_q[i] <= slot_q[i-1];
    end
  end

  // Register file: retiring writeback has priority over a host write to the
  // same register; different registers both update on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RF_N; i++) rf_q[i] <= '0;
    end else begin
      for (int i = 0; i < RF_N; i++) begin
        if (last_slot.v && last_slot.dst == RF_AW'(i)) rf_q[i] <= alu_result;
        else if (rf_wr_en && rf_wr_addr == RF_AW'(i))  rf_q[i] <= rf_wr_data;
      end
    end
  end

  assign alu_opcode      = opcode_q;
  assign alu_operand_a   = operand_a_q;
  assign alu_operand_b   = operand_b_q;
  assign alu_issue_valid = issue_valid_q;
  assign rf_rd_data      = rf_q[rf_rd_addr];
  assign busy            = (fifo_count != '0) | inflight;

  // Queue-full status is carried by instr_ready from the FIFO itself.
  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_alu_issue_unit.sv
// tb_alu_issue_unit: self-checking bench for alu_issue_unit. Models the
// pipelined ALU, records every issued instruction and compares against
// constant vector tables, hand-timed sequences and a sequential-execution
// reference for a random instruction stream.
module tb_alu_issue_unit;
  import alu_issue_pkg::*;

  localparam int DEPTH   = 4;
  localparam int ALU_LAT = 2;
`ifdef ALU_ISSUE_WB_BYPASS_EN
  localparam int DEP_SPACING = 3;
  localparam int FULL_AT     = 6;
`else
  localparam int DEP_SPACING = 4;
  localparam int FULL_AT     = 5;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       instr_valid, instr_ready;
  logic [7:0] instr_data;
  logic [1:0] alu_opcode;
  logic [7:0] alu_operand_a, alu_operand_b, alu_result;
  logic       alu_issue_valid;
  logic       rf_wr_en;
  logic [1:0] rf_wr_addr, rf_rd_addr;
  logic [7:0] rf_wr_data, rf_rd_data;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  alu_issue_unit #(.DEPTH(DEPTH), .ALU_LAT(ALU_LAT)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr_data      (instr_data),
    .alu_opcode      (alu_opcode),
    .alu_operand_a   (alu_operand_a),
    .alu_operand_b   (alu_operand_b),
    .alu_issue_valid (alu_issue_valid),
    .alu_result      (alu_result),
    .rf_wr_en        (rf_wr_en),
    .rf_wr_addr      (rf_wr_addr),
    .rf_wr_data      (rf_wr_data),
    .rf_rd_addr      (rf_rd_addr),
    .rf_rd_data      (rf_rd_data),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_f(logic [1:0] op, logic [7:0] a, logic [7:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      default: return a | b;
    endcase
  endfunction

  function automatic logic [7:0] mk(logic [1:0] op, logic [1:0] d, logic [1:0] a, logic [1:0] b);
    return {op, d, a, b};
  endfunction

  // Behavioural ALU: result appears ALU_LAT edges after the operands; junk
  // on bubbles so a wrongly timed writeback is visible.
  logic [7:0] alu_pipe [ALU_LAT];
  always @(posedge clk) begin
    alu_pipe[0] <= alu_issue_valid ? alu_f(alu_opcode, alu_operand_a, alu_operand_b)
                                   : 8'($urandom);
    for (int i = 1; i < ALU_LAT; i++) alu_pipe[i] <= alu_pipe[i-1];
  end
  assign alu_result = alu_pipe[ALU_LAT-1];

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
  } obs_t;
  obs_t obs_q[$];

  // Issue monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (alu_issue_valid === 1'b1)
      obs_q.push_back('{cyc: cyc, op: alu_opcode, a: alu_operand_a, b: alu_operand_b});
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: timeout, got no response, expected one", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(logic [1:0] a, logic [7:0] d);
    rf_wr_en = 1'b1; rf_wr_addr = a; rf_wr_data = d;
    tick();
    rf_wr_en = 1'b0;
  endtask

  task automatic check_rf(string name, logic [1:0] a, logic [7:0] exp);
    rf_rd_addr = a;
    #1;
    check(name, rf_rd_data, exp);
  endtask

  // Offer one word; returns just after the accepting edge.
  task automatic push(logic [7:0] w, output int acc_cyc, output bit stalled);
    int g = 0;
    stalled = 1'b0;
    instr_valid = 1'b1; instr_data = w;
    while (instr_ready !== 1'b1 && g < 200) begin
      stalled = 1'b1;
      tick();
      g++;
    end
    if (g >= 200) fail("push_ready");
    tick();
    acc_cyc = cyc;
    instr_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int g = 0;
    while (busy !== 1'b0 && g < 200) begin
      tick();
      g++;
    end
    if (g >= 200) fail("wait_idle");
  endtask

  task automatic pop_obs(string name, output obs_t o);
    if (obs_q.size() == 0) begin
      fail(name);
      o = '{cyc: -1, op: 2'b00, a: 8'h00, b: 8'h00};
    end else begin
      o = obs_q.pop_front();
    end
  endtask

  task automatic check_idle_outputs(string tag);
    check({tag, "_op"},    alu_opcode, 0);
    check({tag, "_a"},     alu_operand_a, 0);
    check({tag, "_b"},     alu_operand_b, 0);
    check({tag, "_valid"}, alu_issue_valid, 0);
    check({tag, "_ready"}, instr_ready, 1);
    check({tag, "_busy"},  busy, 0);
    for (int r = 0; r < 4; r++) check_rf($sformatf("%s_rf%0d", tag, r), 2'(r), 8'h00);
  endtask

  typedef struct {
    logic [1:0] op, dst, sa, sb;
    logic [7:0] va, vb, exp;
  } vec_t;

  initial begin
    vec_t vecs[7];
    obs_t o, o2;
    int   pc, pc2, full_k;
    bit   st;
    logic [7:0] m_rf [4];
    obs_t exp_q[$];

    vecs[0] = '{OP_ADD, 2'd0, 2'd0, 2'd1, 8'h05, 8'h03, 8'h08};
    vecs[1] = '{OP_SUB, 2'd0, 2'd1, 2'd0, 8'h00, 8'h01, 8'hFF};
    vecs[2] = '{OP_ADD, 2'd2, 2'd3, 2'd1, 8'hFF, 8'h01, 8'h00};
    vecs[3] = '{OP_AND, 2'd3, 2'd2, 2'd1, 8'hF0, 8'h3C, 8'h30};
    vecs[4] = '{OP_OR,  2'd1, 2'd2, 2'd3, 8'hF0, 8'h0F, 8'hFF};
    vecs[5] = '{OP_ADD, 2'd2, 2'd2, 2'd2, 8'h07, 8'h07, 8'h0E};
    vecs[6] = '{OP_SUB, 2'd1, 2'd3, 2'd0, 8'h10, 8'h20, 8'hF0};

    rst_n = 1'b0; instr_valid = 1'b0; instr_data = '0;
    rf_wr_en = 1'b0; rf_wr_addr = '0; rf_wr_data = '0; rf_rd_addr = '0;
    #12;
    check_idle_outputs("reset");
    #5 rst_n = 1'b1;
    tick();

    // Single-instruction vectors, including wrap-around and dst==src.
    for (int i = 0; i < 7; i++) begin
      host_write(vecs[i].sa, vecs[i].va);
      host_write(vecs[i].sb, vecs[i].vb);
      obs_q.delete();
      push(mk(vecs[i].op, vecs[i].dst, vecs[i].sa, vecs[i].sb), pc, st);
      wait_idle();
      pop_obs($sformatf("vec%0d_issue", i), o);
      check($sformatf("vec%0d_lat", i), o.cyc, pc + 1);
      check($sformatf("vec%0d_op", i),  o.op, vecs[i].op);
      check($sformatf("vec%0d_a", i),   o.a, vecs[i].va);
      check($sformatf("vec%0d_b", i),   o.b, vecs[i].vb);
      check_rf($sformatf("vec%0d_res", i), vecs[i].dst, vecs[i].exp);
    end

    // Independent stream: back-to-back issue and writeback timing.
    host_write(2'd0, 8'h05); host_write(2'd1, 8'h03);
    host_write(2'd2, 8'hF0); host_write(2'd3, 8'h0F);
    obs_q.delete();
    push(mk(OP_ADD, 2'd0, 2'd0, 2'd1), pc, st);
    push(mk(OP_OR,  2'd1, 2'd2, 2'd3), pc2, st);
    tick(); tick();
    check_rf("stream_r0_early", 2'd0, 8'h05);
    tick();
    check_rf("stream_r0_wb", 2'd0, 8'h08);
    check_rf("stream_r1_early", 2'd1, 8'h03);
    tick();
    check_rf("stream_r1_wb", 2'd1, 8'hFF);
    wait_idle();
    pop_obs("stream_i0", o);
    pop_obs("stream_i1", o2);
    check("stream_i0_cyc", o.cyc, pc + 1);
    check("stream_i1_cyc", o2.cyc, pc + 2);
    check("stream_i0_ops", {o.a, o.b}, 16'h0503);
    check("stream_i1_ops", {o2.op, o2.a, o2.b}, {OP_OR, 16'hF00F});

    // RAW stall: dependent SUB spacing and forwarded/written operand.
    host_write(2'd0, 8'h05); host_write(2'd1, 8'h03);
    obs_q.delete();
    push(mk(OP_ADD, 2'd2, 2'd0, 2'd1), pc, st);
    push(mk(OP_SUB, 2'd3, 2'd2, 2'd0), pc2, st);
    wait_idle();
    pop_obs("raw_i0", o);
    pop_obs("raw_i1", o2);
    check("raw_spacing", o2.cyc - o.cyc, DEP_SPACING);
    check("raw_ops", {o2.op, o2.a, o2.b}, {OP_SUB, 16'h0805});
    check_rf("raw_r3", 2'd3, 8'h03);

    // Full queue: dependent chain on r0 backs up the queue.
    host_write(2'd0, 8'h00); host_write(2'd1, 8'h01);
    obs_q.delete();
    full_k = -1;
    for (int k = 0; k < 8; k++) begin
      push(mk(OP_ADD, 2'd0, 2'd0, 2'd1), pc, st);
      if (st && full_k < 0) full_k = k;
    end
    wait_idle();
    check("full_stall_at", full_k, FULL_AT);
    check("full_issue_count", obs_q.size(), 8);
    for (int k = 0; k < 8; k++) begin
      pop_obs($sformatf("full_i%0d", k), o);
      check($sformatf("full_i%0d_a", k), o.a, 8'(k));
    end
    check_rf("full_r0", 2'd0, 8'h08);

    // Writeback vs host write on the same edge.
    host_write(2'd0, 8'h05); host_write(2'd1, 8'h03);
    obs_q.delete();
    push(mk(OP_ADD, 2'd0, 2'd0, 2'd1), pc, st);
    tick(); tick(); tick();
    rf_wr_en = 1'b1; rf_wr_addr = 2'd0; rf_wr_data = 8'hAA;
    tick();
    rf_wr_en = 1'b0;
    check_rf("coll_same_r0", 2'd0, 8'h08);
    push(mk(OP_ADD, 2'd0, 2'd0, 2'd1), pc, st);
    tick(); tick(); tick();
    rf_wr_en = 1'b1; rf_wr_addr = 2'd1; rf_wr_data = 8'h55;
    tick();
    rf_wr_en = 1'b0;
    check_rf("coll_diff_r0", 2'd0, 8'h0B);
    check_rf("coll_diff_r1", 2'd1, 8'h55);
    wait_idle();

    // Reset mid-operation drops queue, tracker and pending writebacks.
    host_write(2'd1, 8'h11);
    push(mk(OP_ADD, 2'd2, 2'd1, 2'd1), pc, st);
    push(mk(OP_OR,  2'd3, 2'd1, 2'd1), pc, st);
    push(mk(OP_ADD, 2'd2, 2'd2, 2'd1), pc, st);
    #2 rst_n = 1'b0;
    #1;
    check_idle_outputs("midrst");
    #3 rst_n = 1'b1;
    repeat (5) tick();
    check_rf("midrst_r2_lost", 2'd2, 8'h00);
    check_rf("midrst_r3_lost", 2'd3, 8'h00);
    check("midrst_busy", busy, 0);
    obs_q.delete();

    // Random stream against sequential-execution reference.
    for (int r = 0; r < 4; r++) begin
      m_rf[r] = 8'($urandom);
      host_write(2'(r), m_rf[r]);
    end
    obs_q.delete();
    exp_q.delete();
    for (int n = 0; n < 40; n++) begin
      logic [7:0] w;
      w = 8'($urandom);
      exp_q.push_back('{cyc: 0, op: w[7:6], a: m_rf[w[3:2]], b: m_rf[w[1:0]]});
      m_rf[w[5:4]] = alu_f(w[7:6], m_rf[w[3:2]], m_rf[w[1:0]]);
      push(w, pc, st);
      repeat ($urandom_range(0, 2)) tick();
    end
    wait_idle();
    check("rand_issue_count", obs_q.size(), 40);
    for (int n = 0; n < 40; n++) begin
      pop_obs($sformatf("rand_i%0d", n), o);
      check($sformatf("rand_i%0d", n), {o.op, o.a, o.b},
            {exp_q[n].op, exp_q[n].a, exp_q[n].b});
    end
    for (int r = 0; r < 4; r++) begin
      tick();
      check_rf($sformatf("rand_r%0d", r), 2'(r), m_rf[r]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
